// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e : receiver frame FSM encoding (IDLE/START/DATA/PARITY/STOP)
//   PAR_EVEN/ODD : values of the parity-mode select input
//   parity_of()  : parity bit a transmitter appends for a given word and mode
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest data word the parity helper accepts; callers zero-extend.
    localparam int unsigned PAR_MAX_W = 16;

    // Even mode: bit makes the total number of ones even; odd mode: odd.
    function automatic logic parity_of(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a 1-cycle tick every
// CLK_FREQ/(BAUD*OVS) clocks (truncated). The transmitter uses OVS=1.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   tick out 1-cycle strobe
module uart_baud_tick #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OVS      = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVS);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling UART receiver.
// Frame: start(0), DATA_W data bits LSB first, parity, stop(1).
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   rx         in  asynchronous serial line, idle high
//   p_sel      in  parity mode (0 even, 1 odd), latched when the start bit is validated
//   data_out   out last received word
//   data_valid out 1-cycle strobe: data_out/p_err/f_err updated
//   p_err      out parity mismatch of last frame
//   f_err      out stop bit read as 0 on last frame
//   busy       out FSM not idle
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DATA_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              p_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              p_err,
    output logic              f_err,
    output logic              busy
);

    localparam int unsigned SCNT_W = $clog2(OVS);
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [SCNT_W-1:0] SMP_PRE  = SCNT_W'(OVS / 2 - 1);
    localparam logic [SCNT_W-1:0] SMP_MID  = SCNT_W'(OVS / 2);
    localparam logic [SCNT_W-1:0] SMP_IDX  = SCNT_W'(OVS / 2 + 1);
`else
    localparam logic [SCNT_W-1:0] SMP_IDX  = SCNT_W'(OVS / 2);
`endif

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .OVS     (OVS)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    uart_state_e       state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              psel_q, psel_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              p_err_q, p_err_d;
    logic              f_err_q, f_err_d;
    logic              fall, sample, sample_evt;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q, maj_d;

    always_comb begin
        maj_d = maj_q;
        if (tick && scnt_q == SMP_PRE) maj_d[0] = rx_s_q;
        if (tick && scnt_q == SMP_MID) maj_d[1] = rx_s_q;
        sample = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s_q) | (maj_q[1] & rx_s_q);
    end

    always_ff @(posedge clk) begin
        if (rst) maj_q <= 2'b11;
        else     maj_q <= maj_d;
    end
`else
    assign sample = rx_s_q;
`endif

    assign fall       = ~rx_s_q & rx_prev_q;
    assign sample_evt = tick && (scnt_q == SMP_IDX);

    always_comb begin
        state_d      = state_q;
        scnt_d       = scnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        psel_d       = psel_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        p_err_d      = p_err_q;
        f_err_d      = f_err_q;

        // Bit-phase counter: zeroed at the start edge, then wraps every OVS ticks
        // so each mid-bit sample lands exactly one bit period after the previous.
        if (state_q != StIdle && tick) begin
            scnt_d = (scnt_q == SCNT_LAST) ? '0 : scnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                scnt_d = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (sample_evt) begin
                    if (!sample) begin
                        state_d = StData;
                        psel_d  = p_sel;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (sample_evt) begin
                    shift_d = {sample, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) state_d = StParity;
                end
            end
            StParity: begin
                if (sample_evt) begin
                    perr_d  = parity_of(PAR_MAX_W'(shift_q), psel_q) != sample;
                    state_d = StStop;
                end
            end
            StStop: begin
                // Back to idle at mid-stop so a following start edge is not missed.
                if (sample_evt) begin
                    data_out_d   = shift_q;
                    p_err_d      = perr_q;
                    f_err_d      = ~sample;
                    data_valid_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= StIdle;
            scnt_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            psel_q       <= PAR_EVEN;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            p_err_q      <= 1'b0;
            f_err_q      <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_prev_q    <= rx_s_q;
            state_q      <= state_d;
            scnt_q       <= scnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            psel_q       <= psel_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            p_err_q      <= p_err_d;
            f_err_q      <= f_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign p_err      = p_err_q;
    assign f_err      = f_err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed bench for uart_rx_oversample.
// 1.6 MHz clock model (20 ns period in sim), 10 kbaud, OVS=16 -> 160 clocks per bit.
// A monitor records every data_valid strobe; directed steps check the recorded frames.
module tb_uart_rx_oversample;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 10_000;
    localparam int unsigned OVS      = 16;
    localparam int unsigned DATA_W   = 7;
    localparam int          BIT_CLKS = 160;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx = 1'b1;
    logic              p_sel = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              p_err;
    logic              f_err;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int exp_v  = 0;

    logic [DATA_W-1:0] cap_data[$];
    logic              cap_p[$];
    logic              cap_f[$];

    uart_rx_oversample #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .OVS     (OVS),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .p_sel     (p_sel),
        .data_out  (data_out),
        .data_valid(data_valid),
        .p_err     (p_err),
        .f_err     (f_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            cap_data.push_back(data_out);
            cap_p.push_back(p_err);
            cap_f.push_back(f_err);
            vcnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b, input bit glitch);
        for (int c = 0; c < BIT_CLKS; c++) begin
            // A one-tick (10 clock) inversion around mid-bit when glitch is set.
            rx = (glitch && c >= 80 && c < 90) ? ~b : b;
            wait_clks(1);
        end
        rx = b;
    endtask

    task automatic send_frame(input logic [6:0] d, input logic pbit, input logic sbit,
                              input int glitch_idx, input bit flip_psel);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (flip_psel && i == 4) p_sel = ~p_sel;
            drive_bit(d[i], i == glitch_idx);
        end
        drive_bit(pbit, 1'b0);
        drive_bit(sbit, 1'b0);
        if (flip_psel) p_sel = ~p_sel;
    endtask

    task automatic chk_frame(input string tag, input int idx, input logic [6:0] d,
                             input logic pe, input logic fe);
        logic [31:0] od, op, of;
        od = 'x;
        op = 'x;
        of = 'x;
        if (idx < cap_data.size()) begin
            od = 32'(cap_data[idx]);
            op = 32'(cap_p[idx]);
            of = 32'(cap_f[idx]);
        end
        chk({tag, "_data"}, od, 32'(d));
        chk({tag, "_perr"}, op, 32'(pe));
        chk({tag, "_ferr"}, of, 32'(fe));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2 * BIT_CLKS);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_p_err", 32'(p_err), 32'h0);
        chk("rst_f_err", 32'(f_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // 1: clean even-parity frame
        p_sel = 1'b0;
        send_frame(7'h55, 1'b0, 1'b1, -1, 1'b0);
        wait_clks(BIT_CLKS);
        exp_v = 1;
        chk("t1_vcnt", 32'(vcnt), 32'(exp_v));
        chk_frame("t1", 0, 7'h55, 1'b0, 1'b0);
        chk("t1_busy", 32'(busy), 32'h0);

        // 2: wrong parity bit
        send_frame(7'h55, 1'b1, 1'b1, -1, 1'b0);
        wait_clks(BIT_CLKS);
        exp_v = 2;
        chk("t2_vcnt", 32'(vcnt), 32'(exp_v));
        chk_frame("t2", 1, 7'h55, 1'b1, 1'b0);

        // 3: framing error, line held low, then recovery frame
        send_frame(7'h12, 1'b0, 1'b0, -1, 1'b0);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        chk("t3_break_busy", 32'(busy), 32'h0);
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        send_frame(7'h2A, 1'b1, 1'b1, -1, 1'b0);
        wait_clks(BIT_CLKS);
        exp_v = 4;
        chk("t3_vcnt", 32'(vcnt), 32'(exp_v));
        chk_frame("t3a", 2, 7'h12, 1'b0, 1'b1);
        chk_frame("t3b", 3, 7'h2A, 1'b0, 1'b0);

        // 4: short low pulse is a false start
        rx = 1'b0;
        wait_clks(20);
        chk("t4_busy_high", 32'(busy), 32'h1);
        wait_clks(20);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        chk("t4_busy_low", 32'(busy), 32'h0);
        chk("t4_vcnt", 32'(vcnt), 32'(exp_v));
        chk("t4_data_held", 32'(data_out), 32'h2A);
`ifdef UART_RX_MAJORITY_EN
        send_frame(7'h55, 1'b0, 1'b1, 2, 1'b0);
        wait_clks(BIT_CLKS);
        exp_v++;
        chk("t4m_vcnt", 32'(vcnt), 32'(exp_v));
        chk_frame("t4m", exp_v - 1, 7'h55, 1'b0, 1'b0);
`endif

        // 5: reset mid-frame during data bit 3 of 7'h33
        p_sel = 1'b0;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        rx = 1'b0;
        wait_clks(80);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        rx  = 1'b1;
        chk("t5_rst_data_out", 32'(data_out), 32'h0);
        chk("t5_rst_p_err", 32'(p_err), 32'h0);
        chk("t5_rst_f_err", 32'(f_err), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_valid", 32'(data_valid), 32'h0);
        wait_clks(2 * BIT_CLKS);
        chk("t5_no_valid", 32'(vcnt), 32'(exp_v));
        send_frame(7'h33, 1'b0, 1'b1, -1, 1'b0);
        wait_clks(BIT_CLKS);
        exp_v++;
        chk("t5_vcnt", 32'(vcnt), 32'(exp_v));
        chk_frame("t5", exp_v - 1, 7'h33, 1'b0, 1'b0);

        // 6: odd parity, back-to-back; p_sel wiggled during the first frame
        p_sel = 1'b1;
        send_frame(7'h7F, 1'b0, 1'b1, -1, 1'b1);
        send_frame(7'h00, 1'b1, 1'b1, -1, 1'b0);
        wait_clks(BIT_CLKS);
        exp_v += 2;
        chk("t6_vcnt", 32'(vcnt), 32'(exp_v));
        chk_frame("t6a", exp_v - 2, 7'h7F, 1'b0, 1'b0);
        chk_frame("t6b", exp_v - 1, 7'h00, 1'b0, 1'b0);
        chk("t6_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
